// File: rtl/mux4_scan_pkg.sv
// Shared types and tables for the 4:1 mux scan sequencer: FSM encoding,
// select-order tables and hold-counter width.
package mux4_scan_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned HoldW = 8;

    // Entry k (mux index visited at step k) lives at bits [2k+1:2k].
    localparam logic [7:0] GrayTable = {2'd1, 2'd3, 2'd2, 2'd0};
    localparam logic [7:0] BinTable  = {2'd3, 2'd2, 2'd1, 2'd0};

    function automatic logic [1:0] step_to_idx(input logic [1:0] step, input bit gray);
        logic [7:0] tbl;
        tbl = gray ? GrayTable : BinTable;
        return tbl[{step, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/mux4_scan_seq_if.sv
// Bundle of the scan handshake, mux drive and result signals; clock and
// reset stay plain ports.
interface mux4_scan_seq_if;
    logic       start;
    logic [3:0] data_in;
    logic       ready;
    logic       i0;
    logic       i1;
    logic       i2;
    logic       i3;
    logic       s0;
    logic       s1;
    logic       y_in;
    logic       bit_valid;
    logic       bit_out;
    logic [1:0] bit_idx;
    logic [3:0] result;
    logic       done;

    modport slave (
        input  start, data_in, y_in,
        output ready, i0, i1, i2, i3, s0, s1, bit_valid, bit_out, bit_idx, result, done
    );

    modport master (
        output start, data_in, y_in,
        input  ready, i0, i1, i2, i3, s0, s1, bit_valid, bit_out, bit_idx, result, done
    );
endinterface

// File: rtl/mux4_sel_gen.sv
// Maps a scan step number to the mux index it visits and the matching
// select lines.
module mux4_sel_gen
    import mux4_scan_pkg::*;
#(
    parameter bit GRAY_ORDER = 1'b1
) (
    input  logic [1:0] step_i,
    output logic [1:0] idx_o,
    output logic       s1_o,
    output logic       s0_o
);

    always_comb begin
        idx_o = step_to_idx(step_i, GRAY_ORDER);
        s1_o  = idx_o[1];
        s0_o  = idx_o[0];
    end

endmodule

// File: rtl/mux4_scan_seq.sv
// Scan sequencer: latches a 4-bit word onto the mux inputs, walks the selects
// through all four indices and reassembles the word from the returned y.
module mux4_scan_seq
    import mux4_scan_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter bit          GRAY_ORDER  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_scan_seq_if.slave   bus
);

    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [3:0]         data_q, data_d;
    logic [3:0]         result_q, result_d;
    logic               bit_valid_q, bit_valid_d;
    logic               bit_out_q, bit_out_d;
    logic [1:0]         bit_idx_q, bit_idx_d;

    logic [1:0]         cur_idx;
    logic               cur_s1;
    logic               cur_s0;
    logic               accept;
    logic               sample;

    mux4_sel_gen #(
        .GRAY_ORDER (GRAY_ORDER)
    ) u_sel_gen (
        .step_i (step_q),
        .idx_o  (cur_idx),
        .s1_o   (cur_s1),
        .s0_o   (cur_s0)
    );

    assign accept = (state_q == StIdle) && bus.start;
    assign sample = (state_q == StScan) && (hold_q == HoldLast);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StScan;
            StScan:  if (sample && (step_q == 2'd3)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        bus.s1    = 1'b0;
        bus.s0    = 1'b0;
        unique case (state_q)
            StIdle:  bus.ready = 1'b1;
            StScan: begin
                bus.s1 = cur_s1;
                bus.s0 = cur_s0;
            end
            StDone:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Counters and capture registers
    always_comb begin
        step_d      = step_q;
        hold_d      = hold_q;
        data_d      = data_q;
        result_d    = result_q;
        bit_valid_d = 1'b0;
        bit_out_d   = bit_out_q;
        bit_idx_d   = bit_idx_q;

        if (accept) begin
            data_d   = bus.data_in;
            result_d = 4'b0000;
            step_d   = 2'd0;
            hold_d   = '0;
        end else if (state_q == StScan) begin
            if (sample) begin
                result_d[cur_idx] = bus.y_in;
                bit_out_d         = bus.y_in;
                bit_idx_d         = cur_idx;
                bit_valid_d       = 1'b1;
                hold_d            = '0;
                // Step 3 parks here; DONE forces selects low and the next accept clears it.
                if (step_q != 2'd3) begin
                    step_d = step_q + 2'd1;
                end
            end else begin
                hold_d = hold_q + HoldW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= 2'd0;
            hold_q      <= '0;
            data_q      <= 4'b0000;
            result_q    <= 4'b0000;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_idx_q   <= 2'd0;
        end else begin
            step_q      <= step_d;
            hold_q      <= hold_d;
            data_q      <= data_d;
            result_q    <= result_d;
            bit_valid_q <= bit_valid_d;
            bit_out_q   <= bit_out_d;
            bit_idx_q   <= bit_idx_d;
        end
    end

    assign bus.i0        = data_q[0];
    assign bus.i1        = data_q[1];
    assign bus.i2        = data_q[2];
    assign bus.i3        = data_q[3];
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_idx   = bit_idx_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_mux4_scan_seq.sv
// Scoreboard bench: three sequencer instances (gray/H=3, binary/H=3, gray/H=1)
// each with a behavioural 4:1 mux closing the y_in loop.
module tb_mux4_scan_seq;

    typedef struct {
        int         inst;
        bit         is_done;
        logic [1:0] idx;
        logic       b;
        logic [3:0] res;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic force0;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    logic [1:0] psel_a;
    logic [1:0] psel_b;
    logic [1:0] psel_c;

    mux4_scan_seq_if bus_a ();
    mux4_scan_seq_if bus_b ();
    mux4_scan_seq_if bus_c ();

    function automatic logic mux_model(input logic [3:0] d, input logic [1:0] s);
        return d[s];
    endfunction

    assign bus_a.y_in = force0 ? 1'b0
                      : mux_model({bus_a.i3, bus_a.i2, bus_a.i1, bus_a.i0}, {bus_a.s1, bus_a.s0});
    assign bus_b.y_in = mux_model({bus_b.i3, bus_b.i2, bus_b.i1, bus_b.i0}, {bus_b.s1, bus_b.s0});
    assign bus_c.y_in = mux_model({bus_c.i3, bus_c.i2, bus_c.i1, bus_c.i0}, {bus_c.s1, bus_c.s0});

    mux4_scan_seq #(.HOLD_CYCLES(3), .GRAY_ORDER(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mux4_scan_seq #(.HOLD_CYCLES(3), .GRAY_ORDER(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    mux4_scan_seq #(.HOLD_CYCLES(1), .GRAY_ORDER(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    task automatic observe(input int inst, input logic bv, input logic bo, input logic [1:0] bi,
                           input logic dn, input logic [3:0] res, input logic [1:0] psel,
                           input logic [1:0] sel, input logic rdy);
        exp_t e;
        if (bv === 1'b1) begin
            if (sb_q.size() == 0) begin
                flag_fail("unexpected_bit");
            end else begin
                e = sb_q.pop_front();
                chk("bit_inst", inst, e.inst);
                chk("bit_kind", 0, e.is_done);
                chk("bit_cycle", cyc, e.cyc);
                chk("bit_idx", bi, e.idx);
                chk("bit_sel", psel, e.idx);
                chk("bit_out", bo, e.b);
            end
        end
        if (dn === 1'b1) begin
            if (sb_q.size() == 0) begin
                flag_fail("unexpected_done");
            end else begin
                e = sb_q.pop_front();
                chk("done_inst", inst, e.inst);
                chk("done_kind", 1, e.is_done);
                chk("done_cycle", cyc, e.cyc);
                chk("done_result", res, e.res);
                chk("done_sel", sel, 2'b00);
                chk("done_ready", rdy, 1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        observe(0, bus_a.bit_valid, bus_a.bit_out, bus_a.bit_idx, bus_a.done, bus_a.result,
                psel_a, {bus_a.s1, bus_a.s0}, bus_a.ready);
        psel_a <= {bus_a.s1, bus_a.s0};
    end

    always @(negedge clk) begin
        observe(1, bus_b.bit_valid, bus_b.bit_out, bus_b.bit_idx, bus_b.done, bus_b.result,
                psel_b, {bus_b.s1, bus_b.s0}, bus_b.ready);
        psel_b <= {bus_b.s1, bus_b.s0};
    end

    always @(negedge clk) begin
        observe(2, bus_c.bit_valid, bus_c.bit_out, bus_c.bit_idx, bus_c.done, bus_c.result,
                psel_c, {bus_c.s1, bus_c.s0}, bus_c.ready);
        psel_c <= {bus_c.s1, bus_c.s0};
    end

    // order: idx visited at step k in bits [7-2k -: 2]; bits: sample k at bit 3-k.
    task automatic push_scan(input int inst, input int acc, input int h, input logic [7:0] order,
                             input logic [3:0] bits, input logic [3:0] res, input int nbits,
                             input bit with_done);
        exp_t e;
        for (int k = 0; k < nbits; k++) begin
            e.inst    = inst;
            e.is_done = 1'b0;
            e.idx     = order[7-2*k -: 2];
            e.b       = bits[3-k];
            e.res     = 4'b0000;
            e.cyc     = acc + (k + 1) * h;
            sb_q.push_back(e);
        end
        if (with_done) begin
            e.inst    = inst;
            e.is_done = 1'b1;
            e.idx     = 2'd0;
            e.b       = 1'b0;
            e.res     = res;
            e.cyc     = acc + 4 * h;
            sb_q.push_back(e);
        end
    endtask

    task automatic set_in(input int inst, input logic st, input logic [3:0] d);
        case (inst)
            0:       begin bus_a.start = st; bus_a.data_in = d; end
            1:       begin bus_b.start = st; bus_b.data_in = d; end
            default: begin bus_c.start = st; bus_c.data_in = d; end
        endcase
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("sb_drain", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_scan(input int inst, input int h, input logic [3:0] data,
                            input logic [7:0] order, input logic [3:0] bits,
                            input logic [3:0] res);
        @(negedge clk);
        push_scan(inst, cyc + 1, h, order, bits, res, 4, 1'b1);
        set_in(inst, 1'b1, data);
        @(negedge clk);
        set_in(inst, 1'b0, 4'h0);
        wait_drain(4 * h + 20);
    endtask

    localparam logic [7:0] GrayOrd = 8'b00_10_11_01;
    localparam logic [7:0] BinOrd  = 8'b00_01_10_11;

    logic [3:0] pat [4];
    int         acc;

    initial begin
        pat[0] = 4'b1001;
        pat[1] = 4'b0101;
        pat[2] = 4'b0011;
        pat[3] = 4'b1100;
        checks = 0;
        errors = 0;
        force0 = 1'b0;
        set_in(0, 1'b0, 4'h0);
        set_in(1, 1'b0, 4'h0);
        set_in(2, 1'b0, 4'h0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready_a", bus_a.ready, 1'b1);
        chk("rst_outs_a", {bus_a.s1, bus_a.s0, bus_a.i3, bus_a.i2, bus_a.i1, bus_a.i0,
                           bus_a.bit_valid, bus_a.bit_out, bus_a.bit_idx, bus_a.result,
                           bus_a.done}, 17'h0);
        chk("rst_ready_b", bus_b.ready, 1'b1);
        chk("rst_ready_c", bus_c.ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Gray order, 1001
        run_scan(0, 3, 4'b1001, GrayOrd, 4'b1010, 4'b1001);
        chk("idle_ready_a", bus_a.ready, 1'b1);
        chk("idle_result_hold_a", bus_a.result, 4'b1001);

        // Binary order, 0110
        run_scan(1, 3, 4'b0110, BinOrd, 4'b0110, 4'b0110);

        // HOLD_CYCLES=1, 1111: samples on four consecutive edges
        run_scan(2, 1, 4'b1111, GrayOrd, 4'b1111, 4'b1111);

        // start held high, data changing every cycle: accepts 14 cycles apart
        @(negedge clk);
        acc = cyc + 1;
        push_scan(0, acc, 3, GrayOrd, 4'b1010, 4'b1001, 4, 1'b1);
        push_scan(0, acc + 14, 3, GrayOrd, 4'b1001, 4'b0011, 4, 1'b1);
        for (int j = 0; j < 15; j++) begin
            set_in(0, 1'b1, pat[j % 4]);
            @(negedge clk);
        end
        set_in(0, 1'b0, 4'h0);
        wait_drain(60);

        // Asynchronous reset mid-scan after the second sample
        @(negedge clk);
        acc = cyc + 1;
        push_scan(0, acc, 3, GrayOrd, 4'b1010, 4'b1001, 2, 1'b0);
        set_in(0, 1'b1, 4'b1001);
        @(negedge clk);
        set_in(0, 1'b0, 4'h0);
        while (cyc < acc + 7) @(negedge clk);
        chk("pre_rst_result", bus_a.result, 4'b0001);
        chk("pre_rst_ready", bus_a.ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", {bus_a.s1, bus_a.s0}, 2'b00);
        chk("mid_rst_result", bus_a.result, 4'b0000);
        chk("mid_rst_ready", bus_a.ready, 1'b1);
        chk("mid_rst_pulses", {bus_a.bit_valid, bus_a.done}, 2'b00);
        chk("mid_rst_data", {bus_a.i3, bus_a.i2, bus_a.i1, bus_a.i0}, 4'b0000);
        chk("mid_rst_sb", sb_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        run_scan(0, 3, 4'b1001, GrayOrd, 4'b1010, 4'b1001);

        // y_in tied low: result must come from y_in, not the latched word
        force0 = 1'b1;
        run_scan(0, 3, 4'b1111, GrayOrd, 4'b0000, 4'b0000);
        force0 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
